// File: rtl/id_stage_pipe.sv
// RV32 instruction-decode stage with a handshaked ID/EX register, load-use stall, flush and illegal detection.
// Define WB_BYPASS_EN to make a same-cycle write-back visible to register reads (write-through).
module id_stage_pipe #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    localparam int unsigned RIDX  = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RIDX-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RIDX-1:0] ex_rs1,
    output logic [RIDX-1:0] ex_rs2,
    output logic [RIDX-1:0] ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_func3,
    output logic [6:0]      ex_func7,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_alu_src,
    output logic            ex_mem_to_reg,
    output logic [1:0]      ex_alu_op,
    output logic            ex_illegal
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            alu_src;
        logic            mem_to_reg;
        logic [1:0]      alu_op;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREGS];
    idex_t           ex_q, ex_d, dec;
    logic            ex_valid_q, ex_valid_d;
    logic            uses_rs1, uses_rs2, uses_rd, known, field_bad;
    logic signed [31:0] imm32;
    logic            load_use, capture;

    // Register read, x0 hardwired to zero
    always_comb begin
        dec.rs1_data = (dec.rs1 == '0) ? '0 : rf_q[dec.rs1];
        dec.rs2_data = (dec.rs2 == '0) ? '0 : rf_q[dec.rs2];
`ifdef WB_BYPASS_EN
        if (wb_we && (wb_rd != '0) && (wb_rd == dec.rs1)) dec.rs1_data = wb_data;
        if (wb_we && (wb_rd != '0) && (wb_rd == dec.rs2)) dec.rs2_data = wb_data;
`endif
    end

    // Low opcode bits other than 11 never match a known opcode, so they fall to default
    always_comb begin
        dec.pc         = if_pc;
        dec.rs1        = if_instr[15 +: RIDX];
        dec.rs2        = if_instr[20 +: RIDX];
        dec.rd         = if_instr[7 +: RIDX];
        dec.opcode     = if_instr[6:0];
        dec.func3      = if_instr[14:12];
        dec.func7      = if_instr[31:25];
        dec.reg_write  = 1'b0;
        dec.mem_read   = 1'b0;
        dec.mem_write  = 1'b0;
        dec.branch     = 1'b0;
        dec.alu_src    = 1'b0;
        dec.mem_to_reg = 1'b0;
        dec.alu_op     = 2'b00;
        uses_rs1       = 1'b0;
        uses_rs2       = 1'b0;
        uses_rd        = 1'b0;
        known          = 1'b1;
        imm32          = '0;
        case (if_instr[6:0])
            OP_REG: begin
                dec.reg_write = 1'b1; dec.alu_op = 2'b10;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1; uses_rd = 1'b1;
            end
            OP_IMM: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 2'b10;
                uses_rs1 = 1'b1; uses_rd = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_LOAD: begin
                dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1;
                uses_rs1 = 1'b1; uses_rd = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_JALR: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1;
                uses_rs1 = 1'b1; uses_rd = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                dec.mem_write = 1'b1; dec.alu_src = 1'b1;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OP_BRANCH: begin
                dec.branch = 1'b1; dec.alu_op = 2'b01;
                uses_rs1 = 1'b1; uses_rs2 = 1'b1;
                imm32 = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; uses_rd = 1'b1;
                imm32 = {if_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; uses_rd = 1'b1;
                imm32 = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
            end
            default: known = 1'b0;
        endcase
        field_bad   = (NREGS == 16) &&
                      ((uses_rs1 && if_instr[19]) || (uses_rs2 && if_instr[24]) || (uses_rd && if_instr[11]));
        dec.illegal = !known || field_bad;
        dec.imm     = XLEN'(imm32);
        if (dec.illegal) begin
            dec.reg_write  = 1'b0;
            dec.mem_read   = 1'b0;
            dec.mem_write  = 1'b0;
            dec.branch     = 1'b0;
            dec.alu_src    = 1'b0;
            dec.mem_to_reg = 1'b0;
            dec.alu_op     = 2'b00;
            uses_rs1       = 1'b0;
            uses_rs2       = 1'b0;
        end
    end

    assign load_use = ex_valid_q && ex_q.mem_read && (ex_q.rd != '0) &&
                      ((uses_rs1 && (dec.rs1 == ex_q.rd)) || (uses_rs2 && (dec.rs2 == ex_q.rd)));
    assign if_ready = flush || ((!ex_valid_q || ex_ready) && !load_use);
    assign capture  = if_valid && if_ready && !flush;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (capture) begin
            ex_valid_d = 1'b1;
            ex_d       = dec;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_we && (wb_rd != '0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_pc         = ex_q.pc;
    assign ex_rs1_data   = ex_q.rs1_data;
    assign ex_rs2_data   = ex_q.rs2_data;
    assign ex_imm        = ex_q.imm;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_opcode     = ex_q.opcode;
    assign ex_func3      = ex_q.func3;
    assign ex_func7      = ex_q.func7;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_branch     = ex_q.branch;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_illegal    = ex_q.illegal;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised successor to the RV32 instruction-decode stage. Decodes the fetched instruction, reads a NREGS x XLEN register file, generates immediate and control bundle, and registers everything into an ID/EX pipeline register. Adds:
- valid/ready handshakes on both sides
- load-use hazard stall
- pipeline flush
- illegal-instruction detection
- RV32E (16-register) support

Sits between the IF stage and the EX stage.

Parameters:
XLEN, 32, datapath / register width (32 or 64; instruction always 32 bits)
NREGS, 32, architectural registers (32 = RV32I, 16 = RV32E); RIDX = $clog2(NREGS)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_valid  in  1  fetch bundle valid
if_ready  out  1  ID accepts fetch bundle this cycle
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction PC
flush  in  1  kill ID/EX contents and drop incoming bundle
wb_we  in  1  write-back enable
wb_rd  in  RIDX  write-back destination
wb_data  in  XLEN  write-back data
ex_valid  out  1  ID/EX bundle valid
ex_ready  in  1  EX consumes bundle this cycle
ex_pc  out  XLEN  registered PC
ex_rs1_data, ex_rs2_data  out  XLEN  registered operands
ex_imm  out  XLEN  sign-extended immediate
ex_rs1, ex_rs2, ex_rd  out  RIDX  register indices
ex_opcode  out  7  opcode
ex_func3  out  3  func3
ex_func7  out  7  func7
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_mem_to_reg  out  1 each  control
ex_alu_op  out  2  ALU op class
ex_illegal  out  1  illegal-instruction flag

Behaviour:
- Reset: ex_valid=0; all ex_* data/control=0; register file cleared to 0. if_ready=1 in the cycle after reset.
- Register file:
  - writes at posedge when wb_we && wb_rd!=0.
  - x0 reads 0 always.
  - reads are combinational from the if_instr fields.
- Handshake:
  - load_use = ex_valid && ex_mem_read && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
  - if_ready = flush || ((!ex_valid || ex_ready) && !load_use).
  - Capture on if_valid && if_ready && !flush → ex_valid=1 next cycle, latency 1.
  - If ex_ready && no capture → ex_valid=0 (bubble).
  - If !ex_ready && ex_valid → all ex_* held stable.
- Load-use: one bubble is inserted. The IF bundle is held (if_ready=0) until the load leaves ID/EX, then accepted.
- Flush: highest priority. Next cycle ex_valid=0 regardless of ex_ready/if_valid; incoming bundle dropped. Flush during reset is ignored.
- Immediates by opcode, sign-extended to XLEN:
  - I: 0000011, 0010011, 1100111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - Others: 0.
- Control:
  - R 0110011: reg_write, alu_op=10
  - I-ALU: reg_write, alu_src, alu_op=10
  - load: reg_write, mem_read, alu_src, mem_to_reg, alu_op=00
  - store: mem_write, alu_src, alu_op=00
  - branch: branch, alu_op=01
  - LUI/AUIPC/JAL/JALR: reg_write, alu_src, alu_op=00
- uses_rs1: all except U/J. uses_rs2: R, S, B.
- Illegal: unknown opcode, or (NREGS=16 and any used register field bit[4]=1), or low bits !=11. On illegal, all control bits =0, ex_illegal=1, ex_valid behaves normally.

Optional Feature:
WB_BYPASS_EN:
- Defined: a read whose index equals wb_rd with wb_we=1 and wb_rd!=0 returns wb_data in the same cycle (write-through).
- Undefined: the read returns the old stored value, and the write is visible from the next cycle.

Test Plan:
1. After reset, wb x5=0x1234. Then present addi x6,x5,-1 (0xFFF28313) with ex_ready=1 → next cycle ex_valid=1, ex_rs1_data=0x1234, ex_imm=0xFFFFFFFF, reg_write=1, alu_src=1, alu_op=10.
2. lw x7,0(x1) captured, then add x8,x7,x2 presented → if_ready=0 one cycle, ex_valid=0 bubble, add accepted the following cycle.
3. ex_ready=0 for 3 cycles with ex_valid=1 → all ex_* unchanged, if_ready=0; ex_ready=1 → next bundle captured.
4. flush=1 while if_valid=1 and ex_valid=1 → next cycle ex_valid=0, dropped instruction never appears.
5. Same-cycle wb x3=0xA5A5 and read of x3 → with WB_BYPASS_EN ex_rs1_data=0xA5A5, without it 0; also write x0=0xFFFF → x0 reads 0.
6. NREGS=16, add x17,x1,x2 → ex_illegal=1, all control bits 0; opcode 0x7F → ex_illegal=1.
